// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an async PWM input,
// summed over 2^AVG_LOG2 periods, with stuck-input detection.
module pwm_capture #(
    parameter int CNT_WIDTH   = 16,
    parameter int AVG_LOG2    = 5,
    parameter int TIMEOUT     = 'hFFFF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          pwm_in,
    output logic [CNT_WIDTH+AVG_LOG2-1:0] high_sum,
    output logic [CNT_WIDTH+AVG_LOG2-1:0] prd_sum,
    output logic                          valid,
    output logic                          stuck,
    output logic                          stuck_level
);

    localparam int SW = CNT_WIDTH + AVG_LOG2;
    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STUCK
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [CNT_WIDTH-1:0]   r_prd_cnt;
    logic [CNT_WIDTH-1:0]   r_high_cnt;
    logic [SW-1:0]          r_prd_acc;
    logic [SW-1:0]          r_high_acc;
    logic [AVG_LOG2-1:0]    r_per_cnt;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_last;
    logic                   w_tmo;
    logic [SW-1:0]          w_prd_next;
    logic [SW-1:0]          w_high_next;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_last = (r_per_cnt == '1);
    assign w_tmo  = (r_prd_cnt == TMO);

    assign w_prd_next  = r_prd_acc + {{AVG_LOG2{1'b0}}, r_prd_cnt};
    assign w_high_next = r_high_acc + {{AVG_LOG2{1'b0}}, r_high_cnt};

    // Synchronizer runs regardless of en so edge history stays valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prd_cnt   <= '0;
            r_high_cnt  <= '0;
            r_prd_acc   <= '0;
            r_high_acc  <= '0;
            r_per_cnt   <= '0;
            prd_sum     <= '0;
            high_sum    <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                r_state    <= IDLE;
                r_prd_cnt  <= '0;
                r_high_cnt <= '0;
                r_prd_acc  <= '0;
                r_high_acc <= '0;
                r_per_cnt  <= '0;
                stuck      <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state    <= RUN;
                            r_prd_cnt  <= CNT_WIDTH'(1);
                            r_high_cnt <= CNT_WIDTH'(1);
                        end
                    end
                    RUN: begin
                        if (w_rise) begin
                            r_prd_cnt  <= CNT_WIDTH'(1);
                            r_high_cnt <= CNT_WIDTH'(1);
                            r_per_cnt  <= r_per_cnt + AVG_LOG2'(1);
                            if (w_last) begin
                                prd_sum    <= w_prd_next;
                                high_sum   <= w_high_next;
                                valid      <= 1'b1;
                                r_prd_acc  <= '0;
                                r_high_acc <= '0;
                            end else begin
                                r_prd_acc  <= w_prd_next;
                                r_high_acc <= w_high_next;
                            end
                        end else if (w_tmo) begin
                            r_state     <= STUCK;
                            stuck       <= 1'b1;
                            stuck_level <= w_s;
                            r_prd_acc   <= '0;
                            r_high_acc  <= '0;
                            r_per_cnt   <= '0;
                        end else begin
                            r_prd_cnt  <= r_prd_cnt + CNT_WIDTH'(1);
                            r_high_cnt <= r_high_cnt
                                        + {{(CNT_WIDTH-1){1'b0}}, w_s};
                        end
                    end
                    STUCK: begin
                        if (w_rise) begin
                            r_state    <= RUN;
                            stuck      <= 1'b0;
                            r_prd_cnt  <= CNT_WIDTH'(1);
                            r_high_cnt <= CNT_WIDTH'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture against a period-level model
// built from the drive history of pwm_in.
module tb_pwm_capture;

    localparam int CW   = 16;
    localparam int AL   = 5;
    localparam int TMO  = 1000;
    localparam int SS   = 2;
    localparam int SW   = CW + AL;
    localparam int NPER = 1 << AL;
    localparam int LAT  = SS + 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          pwm_in;
    logic [SW-1:0] high_sum;
    logic [SW-1:0] prd_sum;
    logic          valid;
    logic          stuck;
    logic          stuck_level;

    pwm_capture #(
        .CNT_WIDTH  (CW),
        .AVG_LOG2   (AL),
        .TIMEOUT    (TMO),
        .SYNC_STAGES(SS)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_sum   (high_sum),
        .prd_sum    (prd_sum),
        .valid      (valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit pw  [0:131071];
    int pre [0:131072];

    logic en_drv, rst_drv, en_q, rst_q;

    // model: 0 idle, 1 run, 2 stuck
    int            m_st;
    int            m_nper;
    longint        m_psum;
    longint        m_hsum;
    int            m_last;
    logic [SW-1:0] e_prd, e_high;
    logic          e_valid, e_stuck, e_lvl;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        m_nper = 0;
        m_psum = 0;
        m_hsum = 0;
    endtask

    // Expected outputs right after posedge number cyc
    task automatic model_edge();
        bit rise;
        e_valid = 1'b0;
        if (!rst_q) begin
            m_st = 0;
            model_clear();
            e_prd = '0; e_high = '0;
            e_stuck = 1'b0; e_lvl = 1'b0;
            return;
        end
        rise = (cyc > LAT) && pw[cyc-LAT] && !pw[cyc-LAT-1];
        if (!en_q) begin
            m_st = 0;
            model_clear();
            e_stuck = 1'b0;
        end else if (rise) begin
            if (m_st == 1) begin
                m_psum += cyc - m_last;
                m_hsum += pre[cyc-LAT] - pre[m_last-LAT];
                m_nper++;
                if (m_nper == NPER) begin
                    e_prd   = SW'(m_psum);
                    e_high  = SW'(m_hsum);
                    e_valid = 1'b1;
                    model_clear();
                end
            end else begin
                m_st = 1;
                model_clear();
                e_stuck = 1'b0;
            end
            m_last = cyc;
        end else if (m_st == 1 && cyc - m_last == TMO) begin
            m_st    = 2;
            e_stuck = 1'b1;
            e_lvl   = pw[cyc-LAT];
            model_clear();
        end
    endtask

    task automatic tick(input logic p);
        @(negedge clk);
        cyc++;
        model_edge();
        check("valid", 64'(valid), 64'(e_valid));
        check("stuck", 64'(stuck), 64'(e_stuck));
        check("stuck_level", 64'(stuck_level), 64'(e_lvl));
        check("prd_sum", 64'(prd_sum), 64'(e_prd));
        check("high_sum", 64'(high_sum), 64'(e_high));
        pwm_in = p;
        en     = en_drv;
        rst_n  = rst_drv;
        pw[cyc]    = p;
        pre[cyc+1] = pre[cyc] + int'(p);
        en_q  = en_drv;
        rst_q = rst_drv;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic pulse(input int h, input int p);
        for (int i = 0; i < p; i++) tick(i < h);
    endtask

    task automatic rand_pulses(input int n, input int pmin, input int pmax);
        int p, h;
        for (int i = 0; i < n; i++) begin
            p = $urandom_range(pmax, pmin);
            h = $urandom_range(p - 1, 1);
            pulse(h, p);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_stuck"}, 64'(stuck), 64'd0);
        check({tag, "_lvl"}, 64'(stuck_level), 64'd0);
        check({tag, "_prd"}, 64'(prd_sum), 64'd0);
        check({tag, "_high"}, 64'(high_sum), 64'd0);
    endtask

    initial begin
        m_st = 0; m_last = 0;
        model_clear();
        e_prd = '0; e_high = '0;
        e_valid = 1'b0; e_stuck = 1'b0; e_lvl = 1'b0;
        pre[0] = 0;
        pwm_in = 1'b0;
        en = 1'b0;
        rst_n = 1'b1;
        en_drv = 1'b0; rst_drv = 1'b0;
        en_q = 1'b0; rst_q = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        hold(1'b0, 3);
        rst_drv = 1'b1;
        en_drv  = 1'b1;
        hold(1'b0, 4);

        // steady 256/64: two windows, then dither 64/65 aligned to a window
        for (int i = 0; i < 2 * NPER; i++) pulse(64, 256);
        for (int i = 0; i <= NPER; i++) pulse(64 + (i % 2), 256);

        rand_pulses(40, 4, 200);

        // stuck low, restart, stuck high
        hold(1'b0, TMO + 200);
        rand_pulses(NPER + 2, 8, 120);
        hold(1'b1, TMO + 200);
        hold(1'b0, 10);

        // periods of exactly TIMEOUT, starting from STUCK
        for (int i = 0; i <= NPER; i++) pulse($urandom_range(900, 1), TMO);

        // en dropped mid-window
        rand_pulses(10, 8, 120);
        en_drv = 1'b0;
        rand_pulses(5, 8, 120);
        en_drv = 1'b1;
        rand_pulses(NPER + 8, 8, 120);

        // async reset mid-window
        rand_pulses(10, 8, 120);
        hold(1'b0, 6);
        rst_drv = 1'b0;
        tick(1'b0);
        #1 check_zero("rst_async");
        hold(1'b0, 5);
        rst_drv = 1'b1;
        hold(1'b0, 5);
        rand_pulses(NPER + 4, 8, 120);
        hold(1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the PWM generator: measures an incoming (possibly dithered) PWM waveform in clk cycles.
- Synchronizes the asynchronous input and detects rising edges.
- Accumulates high-time and period over 2^AVG_LOG2 consecutive periods, so delta-sigma dither on the falling edge resolves to a fractional average.
- Sits on the loopback/monitor path, feeding duty readback to the control logic, and flags a stuck (0%/100% or dead) input.

Parameters:
CNT_WIDTH, 16, width of the per-period cycle counters
AVG_LOG2, 5, log2 of the number of periods summed per result (matches DS fraction bits)
TIMEOUT, 'hFFFF, cycles without a rising edge before declaring stuck; must be <= 2^CNT_WIDTH-1
SYNC_STAGES, 2, synchronizer flops on pwm_in (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  capture enable; low forces IDLE
pwm_in  input  1  asynchronous PWM waveform under measurement
high_sum  output  CNT_WIDTH+AVG_LOG2  sum of high cycles over the last window
prd_sum  output  CNT_WIDTH+AVG_LOG2  sum of period cycles over the last window
valid  output  1  one-cycle pulse when high_sum/prd_sum update
stuck  output  1  no rising edge for TIMEOUT cycles
stuck_level  output  1  synchronized pwm_in level latched when stuck asserted

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, all counters and accumulators 0, synchronizer flops 0.
- Synchronizer: s = output of SYNC_STAGES flop chain; s_d = s delayed one cycle; rise = s & ~s_d. A pwm_in rising edge produces rise SYNC_STAGES+1 cycles later. No glitch filtering; pulses shorter than one clk may be missed.
- Counting in RUN, every cycle without rise: prd_cnt += 1; high_cnt += s.
- On a rise cycle: prd_cnt <= 1, high_cnt <= 1. Period is measured from a rise cycle (inclusive) to the next rise (exclusive).
- States:
  - IDLE: counters held at 0. First rise -> RUN, counters loaded as above, no sample taken (the partial period is discarded).
  - RUN, rise: add prd_cnt to prd_acc and high_cnt to high_acc; per_cnt += 1. When per_cnt wraps from 2^AVG_LOG2-1 to 0, then on the next cycle:
    - prd_sum and high_sum are loaded with the completed sums (including this period);
    - valid = 1 for one cycle;
    - the accumulators restart at 0.
  - RUN, no rise and prd_cnt == TIMEOUT: -> STUCK. stuck <= 1, stuck_level <= s. Accumulators and per_cnt cleared. prd_sum and high_sum hold their last values.
  - RUN, rise in the same cycle that prd_cnt == TIMEOUT: rise wins. The period of TIMEOUT cycles is valid; stay in RUN.
  - STUCK: counters frozen. On rise -> RUN with the same action as IDLE's first rise; stuck <= 0 on that cycle; stuck_level holds.
- en low (synchronous, checked every cycle):
  - -> IDLE; counters, accumulators, per_cnt, stuck and valid cleared.
  - prd_sum, high_sum and stuck_level hold.
  - Synchronizer keeps running.
- en rising: behaves as IDLE; the first rise seen after en goes high starts a window.
- Widths: prd_cnt <= TIMEOUT < 2^CNT_WIDTH, so the sums of 2^AVG_LOG2 periods cannot overflow CNT_WIDTH+AVG_LOG2 bits. high_cnt <= prd_cnt always.
- Asserting reset mid-window discards all partial data; no valid is produced for that window.

Test Plan:
- Steady PWM, period 256 clk, high 64 clk, AVG_LOG2=5 -> first valid 32 periods after the first sampled rise (+1 cycle); prd_sum=8192, high_sum=2048; then repeats every 8192 clk with the same values.
- Dithered high time alternating 64/65 clk, period 256 -> high_sum=2064, prd_sum=8192 each window.
- pwm_in held low after running, TIMEOUT=1000 -> stuck=1, stuck_level=0 exactly 1000 cycles after the last rise cycle; no valid. Repeat with pwm_in held high -> stuck_level=1. Restart the PWM -> stuck clears on the first rise; next valid after 32 full periods.
- Period exactly TIMEOUT with rise on the boundary cycle -> no stuck; prd_sum=32*TIMEOUT.
- en deasserted mid-window, then reasserted -> no valid for the aborted window; the sums keep their previous values until a fresh 32-period window completes.
- rst_n pulsed low mid-window -> all outputs 0 immediately (async); after release, the first valid requires the first rise plus 32 periods.
